// File: rtl/mux2_param.sv
// ---------------------------------------------------------------------------
// Module : mux2_param
// Purpose: Parameterised 2:1 word multiplexer. The selected word is available
//          combinationally on `out`. A registered shadow of it appears on
//          `out_q` one cycle later. A saturating counter tracks how often
//          `sel` changed since the last reset.
//
// Parameters
//   WIDTH      data width of in0, in1, out, out_q (>= 1)
//   CNT_WIDTH  width of sel_chg_cnt (>= 1)
//
// Ports
//   clk          in   1          single clock, rising-edge active
//   rst_n        in   1          synchronous, active-low reset
//   sel          in   1          select: 0 -> in0, 1 -> in1
//   in0          in   WIDTH      data input 0
//   in1          in   WIDTH      data input 1
//   out          out  WIDTH      mux output (combinational by default)
//   out_q        out  WIDTH      registered copy of the mux result
//   sel_chg_cnt  out  CNT_WIDTH  saturating count of sel changes since reset
//
// Build option
//   MUX2_OUT_REG_EN  When defined, `out` is registered as well. It resets to
//                    0 and shows the mux result one cycle late, so it is
//                    identical to out_q. When undefined (the default), `out`
//                    is purely combinational and ignores rst_n.
//                    sel_chg_cnt behaves the same in both builds.
// ---------------------------------------------------------------------------
module mux2_param #(
  parameter int WIDTH     = 5,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sel,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic [CNT_WIDTH-1:0] sel_chg_cnt
);

  logic [WIDTH-1:0]     w_muxOut;
  logic                 w_selChanged;
  logic                 w_cntSaturated;

  logic [WIDTH-1:0]     r_outQ;
  logic                 r_selPrev;
  logic [CNT_WIDTH-1:0] r_selChgCnt;

  // The word select is written as a case rather than a ternary. A ternary
  // with an unknown select merges the bits on which in0 and in1 agree. That
  // would hide a broken select in simulation. Here an X/Z select drives the
  // whole word to X. Synthesis treats the default as don't-care.
  always_comb begin
    w_muxOut = 'x;
    case (sel)
      1'b0:    w_muxOut = in0;
      1'b1:    w_muxOut = in1;
      default: w_muxOut = 'x;
    endcase
  end

  // A change is any difference between this cycle's sel and the sel captured
  // on the previous edge. After reset the captured value is 0. So a high sel
  // in the first cycle out of reset already counts as one change.
  always_comb begin
    w_selChanged   = (sel != r_selPrev);
    w_cntSaturated = &r_selChgCnt;
  end

  // Pipeline register for the selected word. Reset has priority. Otherwise
  // the register captures this cycle's mux result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outQ <= '0;
    end else begin
      r_outQ <= w_muxOut;
    end
  end

  // Select-history flop and change counter. Once every bit of the counter is
  // set, it stops. It never wraps back to zero, so a full count means "at
  // least this many changes".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_selPrev   <= 1'b0;
      r_selChgCnt <= '0;
    end else begin
      r_selPrev <= sel;
      if (w_selChanged && !w_cntSaturated) begin
        r_selChgCnt <= r_selChgCnt + 1'b1;
      end
    end
  end

  assign out_q       = r_outQ;
  assign sel_chg_cnt = r_selChgCnt;

`ifdef MUX2_OUT_REG_EN
  // Registered-output build: out is the same flop as out_q. So the two
  // outputs can never disagree, and the reset to 0 comes for free.
  assign out = r_outQ;
`else
  // Default build: same-cycle mux result, independent of clock and reset.
  assign out = w_muxOut;
`endif

endmodule

// File: tb/tb_mux2_param.sv
// ---------------------------------------------------------------------------
// Testbench for mux2_param.
//
// Two instances share one set of stimulus:
//   - dutA uses the default widths (WIDTH=5, CNT_WIDTH=8).
//   - dutB uses a 2-bit counter, so saturation can be exercised quickly.
//
// Expected values come from a small behavioural model in this bench:
//   - the selected word,
//   - the word captured at the last edge,
//   - a change count clamped with min() against 2**CNT_WIDTH-1.
// ---------------------------------------------------------------------------
module tb_mux2_param;

  localparam int W    = 5;
  localparam int CWA  = 8;
  localparam int CWB  = 2;
  localparam int MAXA = (1 << CWA) - 1;
  localparam int MAXB = (1 << CWB) - 1;

  logic           clk;
  logic           rst_n;
  logic           sel;
  logic [W-1:0]   in0;
  logic [W-1:0]   in1;
  logic [W-1:0]   outA;
  logic [W-1:0]   outQA;
  logic [CWA-1:0] cntA;
  logic [W-1:0]   outB;
  logic [W-1:0]   outQB;
  logic [CWB-1:0] cntB;

  int checks = 0;
  int errors = 0;

  // Model state: last captured word, change counts, previously seen select.
  int mOutQ;
  int mCntA;
  int mCntB;
  int mSelPrev;

  mux2_param #(.WIDTH(W), .CNT_WIDTH(CWA)) dutA (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in0(in0), .in1(in1),
    .out(outA), .out_q(outQA), .sel_chg_cnt(cntA)
  );

  mux2_param #(.WIDTH(W), .CNT_WIDTH(CWB)) dutB (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in0(in0), .in1(in1),
    .out(outB), .out_q(outQB), .sel_chg_cnt(cntB)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected mux word, taken straight from the select rule.
  function automatic int expMux();
    return (sel == 1'b1) ? int'(in1) : int'(in0);
  endfunction

  // Expected value on out. It is the live mux word by default. In the
  // registered-output build it is the captured word instead.
  function automatic int expOut();
`ifdef MUX2_OUT_REG_EN
    return mOutQ;
`else
    return expMux();
`endif
  endfunction

  // Single comparison point: counts the check and reports any failure.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s t=%0t sel=%b in0=%h in1=%h got=%h exp=%h",
             tag, $time, sel, in0, in1, got, exp);
    end
  endtask

  // Drive new inputs, let them settle, then check the (combinational) out of both instances.
  task automatic applyStimulus(input logic r, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    rst_n = r;
    sel   = s;
    in0   = a;
    in1   = b;
    #1;
    checkOutput("outA", 32'(outA), 32'(expOut()));
    checkOutput("outB", 32'(outB), 32'(expOut()));
  endtask

  // Advance one rising edge, update the model with the inputs seen at that edge, then check the clocked outputs.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      mOutQ    = 0;
      mCntA    = 0;
      mCntB    = 0;
      mSelPrev = 0;
    end else begin
      mOutQ = expMux();
      if (int'(sel) != mSelPrev) begin
        mCntA = (mCntA + 1 > MAXA) ? MAXA : mCntA + 1;
        mCntB = (mCntB + 1 > MAXB) ? MAXB : mCntB + 1;
      end
      mSelPrev = int'(sel);
    end
    #1;
    checkOutput("outQA", 32'(outQA), 32'(mOutQ));
    checkOutput("cntA",  32'(cntA),  32'(mCntA));
    checkOutput("outQB", 32'(outQB), 32'(mOutQ));
    checkOutput("cntB",  32'(cntB),  32'(mCntB));
    checkOutput("outA_post", 32'(outA), 32'(expOut()));
  endtask

  initial begin
    int satSeq[5];
    satSeq = '{1, 2, 3, 3, 3};
    mOutQ    = 0;
    mCntA    = 0;
    mCntB    = 0;
    mSelPrev = 0;
    rst_n = 1'b0;
    sel   = 1'b0;
    in0   = '0;
    in1   = '0;
    #1;

    // Reset for two edges while sel toggles. The clocked side stays clear
    // and out keeps following the inputs.
    applyStimulus(1'b0, 1'b1, 5'h07, 5'h18);
    tick();
    applyStimulus(1'b0, 1'b0, 5'h11, 5'h02);
    tick();
    checkOutput("rst_outQ", 32'(outQA), 32'h0);
    checkOutput("rst_cnt",  32'(cntA),  32'h0);

    // Combinational select with fixed values.
    applyStimulus(1'b0, 1'b0, 5'h0A, 5'h15);
`ifndef MUX2_OUT_REG_EN
    checkOutput("comb_sel0", 32'(outA), 32'h0A);
`endif
    applyStimulus(1'b0, 1'b1, 5'h0A, 5'h15);
`ifndef MUX2_OUT_REG_EN
    checkOutput("comb_sel1", 32'(outA), 32'h15);
`endif
    tick();

    // Release reset with sel=1 and in1=1F: out_q shows 1F one edge later.
    applyStimulus(1'b1, 1'b1, 5'h00, 5'h1F);
    tick();
    checkOutput("pipe_outQ", 32'(outQA), 32'h1F);
    checkOutput("pipe_cnt",  32'(cntA),  32'h1);

    // Random sweep of select and data.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'(($urandom >> 3) & 1), W'($urandom), W'($urandom));
      tick();
    end

    // Equal data inputs: out is that value for either select. Edges still count.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'(i & 1), 5'h13, 5'h13);
      checkOutput("eq_model", 32'(expMux()), 32'h13);
      tick();
    end

    // Fresh reset, then five alternating selects. The 2-bit counter must read
    // 1,2,3,3,3.
    applyStimulus(1'b0, 1'b0, 5'h04, 5'h09);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, W'($urandom), W'($urandom));
      tick();
      checkOutput("sat_seq", 32'(cntB), 32'(satSeq[i]));
    end

    // Long toggle run on the wide counter: it saturates at MAXA and holds there.
    for (int i = 0; i < MAXA + 8; i++) begin
      rst_n = 1'b1;
      sel   = ~sel;
      tick();
    end
    checkOutput("sat_wide", 32'(cntA), 32'(MAXA));

    // Reset mid-operation: the clocked side clears on the next edge. out keeps tracking.
    applyStimulus(1'b0, 1'b1, 5'h0C, 5'h1B);
    tick();
    checkOutput("midrst_cnt", 32'(cntA), 32'h0);
    applyStimulus(1'b1, 1'b0, 5'h1E, 5'h01);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
